sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; successor to the fixed 8-bit FIFO in the datapath.
- Width and depth are parametrised.
- Reads and writes are accepted independently and in the same cycle.
- Adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Sits between producer and consumer stages in the same clock domain.

---
 rtl/sync_fifo_param.sv | 83 ++++++++
 tb/tb_sync_fifo_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, an occupancy count,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 2**ADDR_W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wn,
  input  logic              rn,
  input  logic [DATA_W-1:0] DATAIN,
  input  logic              clr_err,
  output logic [DATA_W-1:0] DATAOUT,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_THRESH = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              wr_ok;
  logic              rd_ok;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                        (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign almost_full  = (count >= AF_THRESH);
  assign almost_empty = (count <= AE_THRESH);

  assign wr_ok = wn && !full;
  assign rd_ok = rn && !empty;

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wptr[ADDR_W-1:0]] <= DATAIN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      DATAOUT    <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr    <= rptr + 1'b1;
        DATAOUT <= mem[rptr[ADDR_W-1:0]];
      end
      dout_valid <= rd_ok;

      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A fresh error wins over a simultaneous clear.
      overflow  <= (wn && full)  || (overflow  && !clr_err);
      underflow <= (rn && empty) || (underflow && !clr_err);
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a reference queue and occupancy model
// predict every output after each clock edge.
module tb_sync_fifo_param;

  logic       clock;
  logic       reset;
  logic       wn;
  logic       rn;
  logic [7:0] DATAIN;
  logic       clr_err;
  logic [7:0] DATAOUT;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int         checks;
  int         errors;

  logic [7:0] exp_q[$];
  int         m_count;
  bit         m_ovf;
  bit         m_unf;
  bit         m_valid;
  logic [7:0] m_dout;
  bit         seen_full;

  sync_fifo_param #(
    .DATA_W  (8),
    .ADDR_W  (3),
    .AF_LEVEL(6),
    .AE_LEVEL(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wn          (wn),
    .rn          (rn),
    .DATAIN      (DATAIN),
    .clr_err     (clr_err),
    .DATAOUT     (DATAOUT),
    .dout_valid  (dout_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic check_state();
    checkOutput("count",        32'(count),        32'(m_count));
    checkOutput("empty",        32'(empty),        32'(m_count == 0));
    checkOutput("full",         32'(full),         32'(m_count == 8));
    checkOutput("almost_full",  32'(almost_full),  32'(m_count >= 6));
    checkOutput("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
    checkOutput("overflow",     32'(overflow),     32'(m_ovf));
    checkOutput("underflow",    32'(underflow),    32'(m_unf));
    checkOutput("dout_valid",   32'(dout_valid),   32'(m_valid));
    checkOutput("dataout",      32'(DATAOUT),      32'(m_dout));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_valid = 1'b0;
    m_dout  = 8'h00;
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic applyStimulus(input bit w, input bit r, input logic [7:0] din, input bit clr);
    bit m_full;
    bit m_empty;
    bit wr_ok;
    bit rd_ok;
    wn      = w;
    rn      = r;
    DATAIN  = din;
    clr_err = clr;
    m_full  = (m_count == 8);
    m_empty = (m_count == 0);
    wr_ok   = w && !m_full;
    rd_ok   = r && !m_empty;
    @(posedge clock);
    #1;
    m_valid = rd_ok;
    if (rd_ok) m_dout = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(din);
    m_count = m_count + int'(wr_ok) - int'(rd_ok);
    m_ovf   = (w && m_full)  || (m_ovf && !clr);
    m_unf   = (r && m_empty) || (m_unf && !clr);
    if (full) seen_full = 1'b1;
    check_state();
    wn      = 1'b0;
    rn      = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    seen_full = 1'b0;
    reset     = 1'b0;
    wn        = 1'b0;
    rn        = 1'b0;
    DATAIN    = 8'h00;
    clr_err   = 1'b0;
    model_reset();

    #2;
    check_state();
    #10 reset = 1'b1;
    @(posedge clock);
    #1;
    check_state();

    // Underflow straight out of reset.
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("unf_from_reset", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Fill then overflow attempt, then drain.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
    checkOutput("ovf_count_hold", 32'(count), 32'd8);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("first_after_ovf", 32'(DATAOUT), 32'h10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    end
    checkOutput("drain_last", 32'(DATAOUT), 32'h17);

    // Simultaneous read/write at count 4.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h30 + i), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 8'hBB, 1'b0);
    checkOutput("simul_full_count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    end
    applyStimulus(1'b1, 1'b1, 8'hCC, 1'b0);
    checkOutput("simul_empty_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);

    // Wrap-around with low occupancy.
    seen_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
      applyStimulus(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      applyStimulus(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    end
    checkOutput("wrap_never_full", 32'(seen_full), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

    // Asynchronous reset between edges at count 5.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b0);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_state();
    #2 reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("post_reset_data", 32'(DATAOUT), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
